tx_fifo_funcmod: RTL and testbench

Buffered UART transmitter that consumes the bytes produced by the receive function module and serialises them back onto a TXD line. Upstream logic hands it one byte per iCall/oDone handshake, the same convention the receiver uses. Bytes are queued in a small FIFO and sent as frames of 1 start bit, 8 data bits LSB-first and 2 stop bits. This replaces the hand-written shift sequence in demo top levels and lets the receiver keep accepting bytes while earlier bytes are still being transmitted.

---
 rtl/tx_fifo_funcmod.sv | 166 ++++++++++++++++
 tb/tb_tx_fifo_funcmod.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_fifo_funcmod.sv
// tx_fifo_funcmod: buffered UART transmitter.
// Bytes arrive over an iCall/oDone handshake, are queued in a small FIFO and
// are sent as 11-bit frames: start bit, 8 data bits LSB-first, 2 stop bits.

module tx_fifo_funcmod #(
  parameter int BAUD_DIV   = 434,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  iCall,
  input  logic [7:0]            iData,
  output logic                  oDone,
  output logic                  oFull,
  output logic                  oEmpty,
  output logic [DEPTH_LOG2:0]   oCount,
  output logic                  oBusy,
  output logic                  TXD
);

  localparam int                    DEPTH       = 1 << DEPTH_LOG2;
  localparam int                    BAUD_W      = $clog2(BAUD_DIV);
  localparam logic [BAUD_W-1:0]     BAUD_LAST   = BAUD_W'(BAUD_DIV - 1);
  localparam logic [DEPTH_LOG2:0]   DEPTH_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [3:0]            LAST_BIT    = 4'd10;

  typedef enum logic {
    IDLE,
    SEND
  } txState_t;

  logic [7:0]            fifoMem [DEPTH];
  logic [DEPTH_LOG2-1:0] wrPtr;
  logic [DEPTH_LOG2-1:0] rdPtr;
  logic [DEPTH_LOG2:0]   count;
  logic [DEPTH_LOG2:0]   countNext;
  logic                  doneReg;
  logic                  fullReg;
  logic                  emptyReg;
  logic                  wrEn;
  logic                  pop;
  logic [7:0]            headByte;

  txState_t              state;
  txState_t              stateNext;
  logic [10:0]           frame;
  logic [10:0]           frameNext;
  logic [3:0]            bitIdx;
  logic [3:0]            bitIdxNext;
  logic [BAUD_W-1:0]     baudCnt;
  logic [BAUD_W-1:0]     baudCntNext;
  logic                  txdReg;
  logic                  txdNext;

  // A write is taken only when not in the oDone cycle and the FIFO has room,
  // so a full FIFO simply holds the caller off until a slot frees up.
  assign wrEn     = iCall && !doneReg && (count < DEPTH_COUNT);
  assign headByte = fifoMem[rdPtr];

  // Occupancy changes by +1 on a lone write, -1 on a lone pop, 0 on both.
  always_comb begin
    countNext = count;
    case ({wrEn, pop})
      2'b10:   countNext = count + 1'b1;
      2'b01:   countNext = count - 1'b1;
      default: countNext = count;
    endcase
  end

  // FIFO storage needs no reset; discarding contents is done by the pointers.
  always_ff @(posedge CLOCK) begin
    if (wrEn) begin
      fifoMem[wrPtr] <= iData;
    end
  end

  // Pointers, occupancy, derived flags and the one-cycle accept pulse.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      doneReg  <= 1'b0;
      fullReg  <= 1'b0;
      emptyReg <= 1'b1;
    end else begin
      if (wrEn) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (pop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      count    <= countNext;
      doneReg  <= wrEn;
      fullReg  <= (countNext == DEPTH_COUNT);
      emptyReg <= (countNext == '0);
    end
  end

  // Transmit FSM: loads a frame from the FIFO head, steps through its 11 bits
  // at BAUD_DIV cycles each and chains the next frame with no idle cycle.
  always_comb begin
    stateNext   = state;
    frameNext   = frame;
    bitIdxNext  = bitIdx;
    baudCntNext = baudCnt;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop         = 1'b1;
          frameNext   = {2'b11, headByte, 1'b0};
          bitIdxNext  = 4'd0;
          baudCntNext = '0;
          stateNext   = SEND;
        end
      end
      SEND: begin
        if (baudCnt != BAUD_LAST) begin
          baudCntNext = baudCnt + 1'b1;
        end else if (bitIdx != LAST_BIT) begin
          baudCntNext = '0;
          bitIdxNext  = bitIdx + 4'd1;
        end else if (count != '0) begin
          pop         = 1'b1;
          frameNext   = {2'b11, headByte, 1'b0};
          bitIdxNext  = 4'd0;
          baudCntNext = '0;
        end else begin
          baudCntNext = '0;
          bitIdxNext  = 4'd0;
          stateNext   = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
    txdNext = (stateNext == SEND) ? frameNext[bitIdxNext] : 1'b1;
  end

  // Transmit state register; TXD is registered so the line never glitches.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state   <= IDLE;
      frame   <= '1;
      bitIdx  <= '0;
      baudCnt <= '0;
      txdReg  <= 1'b1;
    end else begin
      state   <= stateNext;
      frame   <= frameNext;
      bitIdx  <= bitIdxNext;
      baudCnt <= baudCntNext;
      txdReg  <= txdNext;
    end
  end

  assign oDone  = doneReg;
  assign oFull  = fullReg;
  assign oEmpty = emptyReg;
  assign oCount = count;
  assign oBusy  = (state == SEND);
  assign TXD    = txdReg;

endmodule

// File: tb/tb_tx_fifo_funcmod.sv
// tb_tx_fifo_funcmod: scoreboard bench for the buffered UART transmitter.
// Stimulus pushes each issued byte into an expected queue; a TXD monitor
// decodes frames independently and compares them against that queue.

module tb_tx_fifo_funcmod;

  localparam int B     = 5;
  localparam int DL    = 4;
  localparam int DEPTH = 16;
  localparam int FRAME = 11 * B;

  logic          CLOCK = 1'b0;
  logic          RESET = 1'b1;
  logic          iCall = 1'b0;
  logic [7:0]    iData = 8'h00;
  logic          oDone;
  logic          oFull;
  logic          oEmpty;
  logic [DL:0]   oCount;
  logic          oBusy;
  logic          TXD;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            doneHigh = 0;
  int            busyHigh = 0;
  logic [7:0]    expQ [$];
  int            starts [$];

  logic          inFrame = 1'b0;
  int            fCyc = 0;
  int            bi = 0;
  logic [10:0]   bits = '0;
  logic          glitch = 1'b0;
  logic [7:0]    expByte;
  logic [10:0]   expFrame;

  tx_fifo_funcmod #(
    .BAUD_DIV   (B),
    .DEPTH_LOG2 (DL)
  ) dut (
    .CLOCK  (CLOCK),
    .RESET  (RESET),
    .iCall  (iCall),
    .iData  (iData),
    .oDone  (oDone),
    .oFull  (oFull),
    .oEmpty (oEmpty),
    .oCount (oCount),
    .oBusy  (oBusy),
    .TXD    (TXD)
  );

  // Free-running clock and a cycle counter used for timing comparisons.
  always #5 CLOCK = ~CLOCK;

  always @(posedge CLOCK) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, actual, required, cyc);
    end
  endtask

  // Issue one byte; the expected byte is queued as soon as it is offered.
  task automatic applyStimulus(input logic [7:0] b, output int acceptCyc);
    int n = 0;
    iData = b;
    iCall = 1'b1;
    expQ.push_back(b);
    do begin
      @(posedge CLOCK);
      #1;
      n++;
    end while (!oDone && n < 500);
    if (!oDone) begin
      checks++;
      errors++;
      $display("[TB] FAIL doneTimeout byte=%02h actual=no oDone required=oDone within 500 cycles", b);
    end
    acceptCyc = cyc;
    iCall = 1'b0;
  endtask

  // Wait until every queued byte has been seen on TXD and the line is idle.
  task automatic waitIdle();
    int n = 0;
    while ((expQ.size() != 0 || inFrame || oBusy) && n < 5000) begin
      @(negedge CLOCK);
      n++;
    end
    if (n >= 5000) begin
      checks++;
      errors++;
      $display("[TB] FAIL drainTimeout actual=%0d bytes pending required=0", expQ.size());
    end
    @(negedge CLOCK);
  endtask

  // TXD monitor: samples every cycle on the falling edge, takes the first
  // sample of each bit as its value and flags any change within a bit.
  initial begin
    forever begin
      @(negedge CLOCK);
      if (oDone) doneHigh++;
      if (oBusy) busyHigh++;
      if (!RESET) begin
        inFrame = 1'b0;
      end else begin
        if (!inFrame && TXD == 1'b0) begin
          inFrame = 1'b1;
          fCyc    = 0;
          glitch  = 1'b0;
          starts.push_back(cyc);
        end
        if (inFrame) begin
          bi = fCyc / B;
          if (fCyc % B == 0) bits[bi] = TXD;
          else if (TXD !== bits[bi]) glitch = 1'b1;
          if (oBusy !== 1'b1) glitch = 1'b1;
          fCyc++;
          if (fCyc == FRAME) begin
            inFrame = 1'b0;
            if (expQ.size() == 0) begin
              checks++;
              errors++;
              $display("[TB] FAIL unexpectedFrame actual=%03h required=no frame", bits);
            end else begin
              expByte  = expQ.pop_front();
              expFrame = {2'b11, expByte, 1'b0};
              checkOutput("frame", bits, expFrame);
            end
            checkOutput("bitTiming", glitch, 0);
          end
        end
      end
    end
  end

  // Watchdog so the run always ends even if the design stalls completely.
  initial begin
    #2000000;
    errors++;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc;
    int base;
    int doneBase;
    int busyBase;
    int target;
    int n;
    logic allHigh;

    // Reset state
    #2 RESET = 1'b0;
    repeat (3) @(posedge CLOCK);
    #1;
    checkOutput("resetTXD", TXD, 1);
    checkOutput("resetDone", oDone, 0);
    checkOutput("resetBusy", oBusy, 0);
    checkOutput("resetCount", oCount, 0);
    checkOutput("resetEmpty", oEmpty, 1);
    checkOutput("resetFull", oFull, 0);
    @(negedge CLOCK);
    RESET = 1'b1;
    repeat (2) @(negedge CLOCK);

    // Single byte: latency, busy length, single oDone, idle afterwards
    $display("[TB] single byte 0x55");
    base = starts.size(); doneBase = doneHigh; busyBase = busyHigh;
    applyStimulus(8'h55, acc);
    waitIdle();
    checkOutput("singleFrames", starts.size() - base, 1);
    if (starts.size() > base) checkOutput("startLatency", starts[base] - acc, 1);
    checkOutput("busyCycles", busyHigh - busyBase, FRAME);
    checkOutput("singleDone", doneHigh - doneBase, 1);
    allHigh = 1'b1;
    for (int i = 0; i < 2 * B; i++) begin
      @(negedge CLOCK);
      if (TXD !== 1'b1) allHigh = 1'b0;
    end
    checkOutput("idleHigh", allHigh, 1);

    // Burst: back-to-back frames, occupancy peak and empty at third pop
    $display("[TB] burst");
    base = starts.size(); doneBase = doneHigh;
    applyStimulus(8'hA5, acc);
    applyStimulus(8'h3C, acc);
    applyStimulus(8'hFF, acc);
    checkOutput("burstPeak", oCount, 2);
    checkOutput("burstNotEmpty", oEmpty, 0);
    n = 0;
    while (starts.size() < base + 3 && n < 1000) begin
      @(negedge CLOCK);
      n++;
    end
    @(negedge CLOCK);
    checkOutput("burstEmpty", oEmpty, 1);
    checkOutput("burstCount", oCount, 0);
    waitIdle();
    if (starts.size() >= base + 3) begin
      checkOutput("pitch1", starts[base + 1] - starts[base], FRAME);
      checkOutput("pitch2", starts[base + 2] - starts[base + 1], FRAME);
    end else begin
      checks++;
      errors++;
      $display("[TB] FAIL burstFrames actual=%0d required=3", starts.size() - base);
    end
    checkOutput("burstDone", doneHigh - doneBase, 3);

    // Overflow: 17 bytes fill the FIFO, the 18th waits for the first pop
    $display("[TB] overflow");
    base = starts.size(); doneBase = doneHigh;
    for (int v = 0; v < 17; v++) applyStimulus(8'(v), acc);
    checkOutput("overflowFull", oFull, 1);
    checkOutput("overflowCount", oCount, DEPTH);
    checkOutput("overflowNotEmpty", oEmpty, 0);
    applyStimulus(8'h11, acc);
    if (starts.size() > base) checkOutput("fullAccept", acc - starts[base], FRAME + 1);
    checkOutput("fullAfterPop", oFull, 1);
    waitIdle();
    checkOutput("overflowDone", doneHigh - doneBase, 18);

    // Wrap-around: 40 incrementing bytes through the 16-entry FIFO
    $display("[TB] wrap-around");
    for (int i = 0; i < 40; i++) applyStimulus(8'(8'h20 + i), acc);
    waitIdle();

    // Randomized bytes with random gaps, including long idle periods
    $display("[TB] random");
    for (int i = 0; i < 30; i++) begin
      applyStimulus(8'($urandom_range(0, 255)), acc);
      if ($urandom_range(0, 7) == 0) repeat ($urandom_range(40, 80)) @(posedge CLOCK);
      else repeat ($urandom_range(0, 3)) @(posedge CLOCK);
      #1;
    end
    waitIdle();

    // Loopback byte set delivered through the same handshake as the receiver
    $display("[TB] loopback bytes");
    applyStimulus(8'h00, acc);
    applyStimulus(8'h7E, acc);
    applyStimulus(8'h81, acc);
    waitIdle();

    // Reset mid-frame during data bit 3 with 5 bytes queued
    $display("[TB] reset mid-frame");
    base = starts.size();
    for (int i = 0; i < 6; i++) applyStimulus(8'(8'hC0 + i), acc);
    checkOutput("preResetCount", oCount, 5);
    target = (starts.size() > base) ? starts[base] + 4 * B + 2 : cyc;
    n = 0;
    while (cyc < target && n < 1000) begin
      @(posedge CLOCK);
      #1;
      n++;
    end
    RESET = 1'b0;
    #1;
    checkOutput("asyncTXD", TXD, 1);
    checkOutput("asyncCount", oCount, 0);
    checkOutput("asyncBusy", oBusy, 0);
    checkOutput("asyncDone", oDone, 0);
    checkOutput("asyncEmpty", oEmpty, 1);
    expQ.delete();
    repeat (3) @(negedge CLOCK);
    RESET = 1'b1;
    base = starts.size();
    allHigh = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLOCK);
      if (TXD !== 1'b1) allHigh = 1'b0;
    end
    checkOutput("noSpuriousFrame", starts.size() - base, 0);
    checkOutput("postResetIdle", allHigh, 1);
    checkOutput("postResetCount", oCount, 0);
    applyStimulus(8'h3A, acc);
    waitIdle();
    checkOutput("postResetFrames", starts.size() - base, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
